noc_input_fifo: RTL

//  Per-port input buffer of the router; sits directly upstream of LBDR.

---
 rtl/noc_input_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/noc_input_fifo.sv
// Router per-port input buffer: circular flit FIFO with show-ahead head view,
// credit return to the upstream router, and read-side packet framing check.
module noc_input_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  rd_en,
    output logic                  credit_out,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    pkt_state_e       state_q, state_d;

    logic             rd_ok_c;
    logic             wr_ok_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy flags come straight from the registered count.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A full FIFO always has a head to pop, so rd_en frees the slot for the write.
    assign rd_ok_c = rd_en & ~empty;
    assign wr_ok_c = valid_in & (~full | rd_en);

    assign flit_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign flit_id    = flit_out[DATA_WIDTH-1 -: 3];
    assign dst_addr   = flit_out[DATA_WIDTH-4 -: 4];
    assign credit_out = credit_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

    // Pointer, occupancy and sticky-overflow next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = rd_ok_c;
        overflow_d = overflow_q;

        if (wr_ok_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_ok_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({wr_ok_c, rd_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (valid_in && full && !rd_en) begin
            overflow_d = 1'b1;
        end
    end

    // Framing FSM: advances only on a successful pop of the head flit.
    always_comb begin
        state_d     = state_q;
        frame_err_d = frame_err_q;

        if (rd_ok_c) begin
            unique case (state_q)
                IDLE: begin
                    if (flit_id == HEADER) begin
                        state_d = BODY;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                BODY: begin
                    if (flit_id == PAYLOAD) begin
                        state_d = BODY;
                    end else if (flit_id == TAIL) begin
                        state_d = IDLE;
                    end else begin
                        // A header mid-packet starts a new packet; unknown ids hold state.
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_c) begin
            mem_q[wr_ptr_q] <= flit_in;
        end
    end

endmodule
